// File: rtl/sp_sync_ctrl_pkg.sv
// Shared definitions for the serial receive sync controller: state encoding,
// default comma character and a small elaboration-time helper.
package sp_sync_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_COUNT     = 2'd1,
        ST_ACTIVE    = 2'd2,
        ST_SLIP_WAIT = 2'd3
    } sync_state_e;

    localparam logic [7:0] BC_CHAR_DEFAULT = 8'hBC;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sp_sync_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sp_sync_ctrl_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear, else increment unless already at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + W'(1);
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/sp_sync_ctrl.sv
// Comma-based alignment/sync controller for the serial-to-parallel receive
// path: hunts for BC_REQ consecutive commas, requests bit-slips while no comma
// shows up, forwards data bytes once active and drops out when the link goes quiet.
module sp_sync_ctrl
    import sp_sync_ctrl_pkg::*;
#(
    parameter logic [7:0] BC_CHAR      = BC_CHAR_DEFAULT,
    parameter int         BC_REQ       = 4,
    parameter int         SLIP_TIMEOUT = 16,
    parameter int         SLIP_HOLD    = 8,
    parameter int         LOSS_REQ     = 4
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_in_vld,
    output logic       slip,
    output logic       active,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [2:0] bc_count,
    output logic [7:0] sync_loss_cnt
);

    // One timer serves both the search timeout and the post-slip settle time.
    localparam int TMR_W  = $clog2(max_int(SLIP_TIMEOUT, SLIP_HOLD) + 1);
    localparam int LOSS_W = $clog2(LOSS_REQ + 1);

    sync_state_e       state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              slip_q, slip_d;
    logic              active_q, active_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic [2:0]        bc_q, bc_d;

    logic              loss_inc, loss_clr, sl_inc;
    logic [LOSS_W-1:0] loss_cnt;

    logic is_comma, is_data;
    assign is_comma = byte_in_vld && (byte_in == BC_CHAR);
    assign is_data  = byte_in_vld && (byte_in != BC_CHAR);

    // Next-state and registered-output computation for the sync FSM.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        slip_d   = 1'b0;
        active_d = active_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        bc_d     = bc_q;
        loss_inc = 1'b0;
        loss_clr = 1'b1;
        sl_inc   = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                active_d = 1'b0;
                bc_d     = 3'd0;
                if (is_comma) begin
                    // A comma beats the timeout landing on the same cycle.
                    timer_d = '0;
                    bc_d    = 3'd1;
                    if (BC_REQ == 1) begin
                        state_d  = ST_ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end else if (timer_q == TMR_W'(SLIP_TIMEOUT - 1)) begin
                    slip_d  = 1'b1;
                    timer_d = '0;
                    state_d = ST_SLIP_WAIT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_SLIP_WAIT: begin
                // Deserializer is re-aligning; everything on the input is ignored.
                if (timer_q == TMR_W'(SLIP_HOLD - 1)) begin
                    timer_d = '0;
                    state_d = ST_SEARCH;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_COUNT: begin
                if (is_comma) begin
                    bc_d = bc_q + 3'd1;
                    if (bc_q == 3'(BC_REQ - 1)) begin
                        state_d  = ST_ACTIVE;
                        active_d = 1'b1;
                    end
                end else if (is_data) begin
                    bc_d    = 3'd0;
                    timer_d = '0;
                    state_d = ST_SEARCH;
                end
            end
            ST_ACTIVE: begin
                loss_clr = byte_in_vld;
                if (is_data) begin
                    data_d  = byte_in;
                    valid_d = 1'b1;
                end else if (!byte_in_vld) begin
                    if (loss_cnt == LOSS_W'(LOSS_REQ - 1)) begin
                        state_d  = ST_SEARCH;
                        active_d = 1'b0;
                        bc_d     = 3'd0;
                        timer_d  = '0;
                        loss_clr = 1'b1;
                        sl_inc   = 1'b1;
                    end else begin
                        loss_inc = 1'b1;
                    end
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // State and output registers, synchronously reset.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q  <= ST_SEARCH;
            timer_q  <= '0;
            slip_q   <= 1'b0;
            active_q <= 1'b0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            bc_q     <= 3'd0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            slip_q   <= slip_d;
            active_q <= active_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            bc_q     <= bc_d;
        end
    end

    // Consecutive silent cycles while active.
    sp_sync_ctrl_sat_cnt #(.W(LOSS_W)) u_loss_cnt (
        .clk   (clk_4f),
        .reset (reset),
        .inc   (loss_inc),
        .clr   (loss_clr),
        .cnt   (loss_cnt)
    );

    // Number of ACTIVE->SEARCH drops, sticks at 255.
    sp_sync_ctrl_sat_cnt #(.W(8)) u_sync_loss_cnt (
        .clk   (clk_4f),
        .reset (reset),
        .inc   (sl_inc),
        .clr   (1'b0),
        .cnt   (sync_loss_cnt)
    );

    assign slip      = slip_q;
    assign active    = active_q;
    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign bc_count  = bc_q;

endmodule

// File: tb/tb_sp_sync_ctrl.sv
// Directed bench for sp_sync_ctrl with hand-computed expectations.
module tb_sp_sync_ctrl;

    logic       clk_4f = 1'b0;
    logic       reset;
    logic [7:0] byte_in;
    logic       byte_in_vld;
    logic       slip;
    logic       active;
    logic [7:0] data_out;
    logic       valid_out;
    logic [2:0] bc_count;
    logic [7:0] sync_loss_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    sp_sync_ctrl dut (
        .clk_4f        (clk_4f),
        .reset         (reset),
        .byte_in       (byte_in),
        .byte_in_vld   (byte_in_vld),
        .slip          (slip),
        .active        (active),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .bc_count      (bc_count),
        .sync_loss_cnt (sync_loss_cnt)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one input byte, clock it in, then settle past the edge.
    task automatic cyc(input logic v, input logic [7:0] b);
        byte_in_vld = v;
        byte_in     = b;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_slip"},   32'(slip),          0);
        chk({tag, "_active"}, 32'(active),        0);
        chk({tag, "_data"},   32'(data_out),      0);
        chk({tag, "_valid"},  32'(valid_out),     0);
        chk({tag, "_bc"},     32'(bc_count),      0);
        chk({tag, "_sloss"},  32'(sync_loss_cnt), 0);
    endtask

    initial begin
        int first;
        reset       = 1'b1;
        byte_in     = 8'h00;
        byte_in_vld = 1'b0;

        // 1: reset for 3 cycles, then four commas reach ACTIVE
        for (int i = 0; i < 3; i++) cyc(0, 8'h00);
        chk_all_zero("reset");
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 8'hBC);
            chk("sync_bc",     32'(bc_count),  32'(i));
            chk("sync_active", 32'(active),    (i == 4) ? 1 : 0);
            chk("sync_valid",  32'(valid_out), 0);
        end

        // 2: data, idle comma, data
        cyc(1, 8'h5A);
        chk("fwd_data0", 32'(data_out), 32'h5A);
        chk("fwd_vld0",  32'(valid_out), 1);
        cyc(1, 8'hBC);
        chk("idle_vld",  32'(valid_out), 0);
        chk("idle_hold", 32'(data_out), 32'h5A);
        chk("idle_bc",   32'(bc_count), 4);
        cyc(1, 8'h3C);
        chk("fwd_data1", 32'(data_out), 32'h3C);
        chk("fwd_vld1",  32'(valid_out), 1);

        // 5: three silent, one valid byte, then four silent -> loss
        for (int i = 0; i < 3; i++) begin
            cyc(0, 8'h00);
            chk("silent_active", 32'(active), 1);
            chk("silent_vld",    32'(valid_out), 0);
        end
        cyc(1, 8'h77);
        chk("resume_vld",  32'(valid_out), 1);
        chk("resume_data", 32'(data_out), 32'h77);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 8'h00);
            chk("loss_active", 32'(active), (i == 4) ? 0 : 1);
        end
        chk("loss_sloss", 32'(sync_loss_cnt), 1);
        chk("loss_bc",    32'(bc_count), 0);
        chk("loss_vld",   32'(valid_out), 0);

        // 6: re-sync, stream data, reset mid-ACTIVE
        for (int i = 0; i < 4; i++) cyc(1, 8'hBC);
        chk("resync_active", 32'(active), 1);
        cyc(1, 8'h42);
        chk("resync_data", 32'(data_out), 32'h42);
        reset = 1'b1;
        cyc(1, 8'h99);
        chk_all_zero("midreset");
        reset = 1'b0;

        // 3: broken comma run
        cyc(1, 8'hBC);  chk("run_bc0", 32'(bc_count), 1);
        cyc(1, 8'hBC);  chk("run_bc1", 32'(bc_count), 2);
        cyc(1, 8'h11);  chk("run_bc2", 32'(bc_count), 0);
        cyc(1, 8'hBC);  chk("run_bc3", 32'(bc_count), 1);
        chk("run_active", 32'(active), 0);

        // 4: slip after 16 non-comma cycles, 24-cycle spacing, comma ignored in hold
        reset = 1'b1;
        cyc(0, 8'h00);
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cyc(1, 8'h00);
            chk("slip_first", 32'(slip), (k == 16) ? 1 : 0);
        end
        first = 0;
        for (int k = 17; k <= 60; k++) begin
            cyc(1, (k == 18) ? 8'hBC : 8'h00);
            if (k == 17) chk("slip_width", 32'(slip), 0);
            if (k == 18) chk("slip_wait_bc", 32'(bc_count), 0);
            if (k == 41) chk("slip_width2", 32'(slip), 0);
            if (slip && first == 0) first = k;
        end
        chk("slip_gap", 32'(first - 16), 24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
